fifo_write_ctrl: RTL

- Write-side controller of the synchronous FIFO.
- Owns the write pointer and drives the memory write strobe and address.
- Produces the registered full, almost-full and occupancy status consumed by the producer.
- Sits directly upstream of the full-flag comparator and the FIFO memory. It feeds them the Gray-coded write pointer and compares it against the Gray-coded read pointer from the read-side controller.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_write_ctrl_if.sv | 27 ++
 rtl/gray_counter.sv | 41 ++++
 rtl/fifo_write_ctrl.sv | 76 +++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and pointer-code helpers for both sides of the synchronous FIFO.
// Conversion functions work on 32-bit vectors; callers zero-extend and truncate to their width.
package fifo_pkg;

  localparam int unsigned FIFO_SIZE     = 4;
  localparam int unsigned FIFO_AF_LEVEL = 2;

  typedef logic [FIFO_SIZE-1:0] ptr_t;

  // Number of storage slots addressed by a pointer of the given width (one wrap bit).
  function automatic int unsigned depth_of(input int unsigned size);
    return 32'd1 << (size - 1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits stay zero through the cascade, so any narrower width converts correctly.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_write_ctrl_if.sv
// Producer-facing bus of the FIFO write controller: push request, read pointer in, status out.
interface fifo_write_ctrl_if #(
  parameter int unsigned SIZE = fifo_pkg::FIFO_SIZE
);

  logic            wr_en;
  logic            clr_overflow;
  logic [SIZE-1:0] read_pointer;
  logic [SIZE-1:0] write_pointer;
  logic [SIZE-2:0] write_addr;
  logic            mem_we;
  logic            full_flag;
  logic            almost_full;
  logic [SIZE-1:0] wr_count;
  logic            overflow;

  modport master (
    output wr_en, clr_overflow, read_pointer,
    input  write_pointer, write_addr, mem_we, full_flag, almost_full, wr_count, overflow
  );

  modport slave (
    input  wr_en, clr_overflow, read_pointer,
    output write_pointer, write_addr, mem_we, full_flag, almost_full, wr_count, overflow
  );

endinterface

// File: rtl/gray_counter.sv
// Registered binary counter with a Gray shadow updated on the same edge, so the Gray output
// never passes through logic after the flop. Shared by the read and write controllers.
module gray_counter
  import fifo_pkg::*;
#(
  parameter int unsigned W = FIFO_SIZE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] bin_q_o,
  output logic [W-1:0] gray_q_o,
  output logic [W-1:0] bin_d_o,
  output logic [W-1:0] gray_d_o
);

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;

  always_comb begin
    bin_d  = bin_q + W'(en_i);
    gray_d = W'(bin2gray(32'(bin_d)));
  end

  // NOTE: state flops use <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin_q_o  = bin_q;
  assign gray_q_o = gray_q;
  assign bin_d_o  = bin_d;
  assign gray_d_o = gray_d;

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side controller of the synchronous FIFO: owns the write pointer, gates memory writes,
// and produces registered full / almost-full / occupancy / sticky-overflow status.
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned SIZE     = FIFO_SIZE,
  parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL
) (
  input logic              clk,
  input logic              rst_n,
  fifo_write_ctrl_if.slave bus
);

  localparam int unsigned     DEPTH     = depth_of(SIZE);
  localparam logic [SIZE-1:0] AF_THRESH = SIZE'(DEPTH - AF_LEVEL);

  logic            mem_we;
  logic [SIZE-1:0] wbin_q, wbin_d;
  logic [SIZE-1:0] wgray_q, wgray_d;
  logic [SIZE-1:0] rbin;
  logic [SIZE-1:0] count_d, count_q;
  logic            full_d, full_q;
  logic            af_d, af_q;
  logic            ovf_d, ovf_q;

  // Reset gates the strobe so nothing lands in memory while the pointers are being cleared.
  assign mem_we = bus.wr_en & ~full_q & rst_n;

  gray_counter #(
    .W (SIZE)
  ) u_wptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (mem_we),
    .bin_q_o  (wbin_q),
    .gray_q_o (wgray_q),
    .bin_d_o  (wbin_d),
    .gray_d_o (wgray_d)
  );

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    rbin    = SIZE'(gray2bin(32'(bus.read_pointer)));
    count_d = wbin_d - rbin;
    // Same Gray-domain test as the downstream full comparator: top two bits differ, rest equal.
    full_d  = (wgray_d[SIZE-1] != bus.read_pointer[SIZE-1]) &&
              (wgray_d[SIZE-2] != bus.read_pointer[SIZE-2]) &&
              (wgray_d[SIZE-3:0] == bus.read_pointer[SIZE-3:0]);
    af_d    = (count_d >= AF_THRESH);
    // Set dominates clear so a rejected push is never lost.
    ovf_d   = (bus.wr_en & full_q) | (ovf_q & ~bus.clr_overflow);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.mem_we        = mem_we;
  assign bus.write_pointer = wgray_q;
  assign bus.write_addr    = wbin_q[SIZE-2:0];
  assign bus.full_flag     = full_q;
  assign bus.almost_full   = af_q;
  assign bus.wr_count      = count_q;
  assign bus.overflow      = ovf_q;

endmodule
